// File: rtl/pipe_skid_stage.sv
// Two-entry elastic valid/ready stage (main + skid register); in_ready and out_valid come straight from state flops.
// Latency: one cycle from in_fire to out_valid. Backpressure: absorbs one extra beat in skid, then deasserts in_ready.
// Optional stall counter enabled by defining PIPE_SKID_STALL_CNT_EN; otherwise stall_cnt is tied to zero.
module pipe_skid_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // Flush drops everything, including a beat accepted in the same cycle.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (flush) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: accepted beats are queued as expected, emitted beats are queued as observed.
module tb_pipe_skid_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [31:0] stall_cnt;

    int total;
    int bad;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    pipe_skid_stage #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Sample handshakes at the falling edge, then advance past the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (flush) begin
            while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
        end else if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
        end
        if (out_valid && out_ready) obs_q.push_back(out_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        logic [7:0] o;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
        total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_out_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 8'h11) begin bad++; $display("FAIL first_out_data got=%h want=11", out_data); end
        out_ready = 1'b1;
        tick();
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL first_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL first_sb_data got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_streaming();
        logic [7:0] e;
        logic [7:0] o;
        int rdy_bad;
        int lat_bad;
        rdy_bad = 0; lat_bad = 0;
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            if (in_ready !== 1'b1) rdy_bad++;
            tick();
            if (out_valid !== 1'b1 || out_data !== 8'(i)) lat_bad++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        total++; if (rdy_bad != 0) begin bad++; $display("FAIL stream_in_ready low_cycles got=%0d want=0", rdy_bad); end
        total++; if (lat_bad != 0) begin bad++; $display("FAIL stream_latency wrong_cycles got=%0d want=0", lat_bad); end
        total++; if (obs_q.size() != 16 || exp_q.size() != 16) begin
            bad++; $display("FAIL stream_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL stream_sb_data got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b want=1", in_ready); end
        in_data = 8'hA2;
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", in_ready); end
        in_data = 8'hA3;
        repeat (3) tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 8'hA1) begin bad++; $display("FAIL bp_hold_data got=%h want=a1", out_data); end
        total++; if (exp_q.size() != 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", exp_q.size()); end
    endtask

    task automatic test_drain();
        logic [7:0] e;
        logic [7:0] o;
        out_ready = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready_back got=%b want=1", in_ready); end
        total++; if (out_data !== 8'hA2) begin bad++; $display("FAIL drain_second got=%h want=a2", out_data); end
        tick();
        in_valid = 1'b0;
        total++; if (out_data !== 8'hA3) begin bad++; $display("FAIL drain_third got=%h want=a3", out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", out_valid); end
        total++; if (obs_q.size() != 3 || exp_q.size() != 3) begin
            bad++; $display("FAIL drain_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL drain_sb_data got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hB1;
        tick();
        in_data = 8'hB2;
        tick();
        in_data = 8'hB0; flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        total++; if (obs_q.size() != 0 || exp_q.size() != 0) begin
            bad++; $display("FAIL flush_nothing_emitted got=%0d want=0", obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hC5;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre_valid got=%b want=1", out_valid); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_in_ready got=%b want=1", in_ready); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL areset_out_data got=%h want=00", out_data); end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_counter();
        logic [31:0] want5;
`ifdef PIPE_SKID_STALL_CNT_EN
        want5 = 32'd5;
`else
        want5 = 32'd0;
`endif
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hD1;
        tick();
        in_valid = 1'b0;
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL cnt_start got=%0d want=0", stall_cnt); end
        repeat (5) tick();
        total++; if (stall_cnt !== want5) begin bad++; $display("FAIL cnt_five got=%0d want=%0d", stall_cnt, want5); end
        total++; if (out_data !== 8'hD1) begin bad++; $display("FAIL cnt_hold_data got=%h want=d1", out_data); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL cnt_flush got=%0d want=0", stall_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cnt_flush_valid got=%b want=0", out_valid); end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_drain();
        test_flush();
        test_async_reset();
        test_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Two-entry elastic valid/ready pipeline stage (main register plus skid register).
- Sits directly upstream of the datapath's enable flops. Produces registered data/valid and back-pressure so downstream enable-gated flops are loaded only on a completed handshake.
- Breaks the combinational ready path: in_ready is a flop output, not a function of out_ready.
- Sustains full throughput, one transfer per cycle.

Parameters:
- WIDTH, 8, payload width in bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted while 0; deassertion is synchronous to clk externally.
- flush  input  1  synchronous discard of all held entries.
- in_valid  input  1  upstream has data on in_data.
- in_ready  output  1  stage can accept this cycle (registered).
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry (registered).
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload, driven from the main register.
- stall_cnt  output  32  out_valid&&!out_ready cycle count (see Optional Feature).

Behaviour:
- Handshake:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
  - No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- State (2 bits): EMPTY, ONE (main valid), FULL (main+skid valid).
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL). Both are decoded directly from state flops.
- Transitions (flush==0):
  - EMPTY: in_fire -> main<=in_data, ONE; else stay.
  - ONE: in_fire&&out_fire -> main<=in_data, ONE. out_fire only -> EMPTY. in_fire only -> skid<=in_data, FULL. Neither -> stay.
  - FULL: in_fire impossible. out_fire -> main<=skid, ONE. Else stay.
- Latency: in_fire at cycle N -> out_valid with that data at N+1 if the stage was EMPTY or draining.
- Ordering: strict FIFO. Skid data is never emitted before main data.
- Stability: while out_valid&&!out_ready, out_data and out_valid hold unchanged.
- flush: highest priority, synchronous. Next state EMPTY regardless of fires. Any in_fire in the flush cycle is dropped. Data registers are not cleared.
- Reset (reset==0), asynchronous:
  - state=EMPTY, so out_valid=0 and in_ready=1.
  - main, skid and out_data are 0.
  - stall_cnt is 0.
  - Reset mid-transfer discards both entries.
- Data registers load only on the transitions listed above. Otherwise they hold.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with out_valid&&!out_ready.
  - Saturates at 32'hFFFF_FFFF, no wrap.
  - Cleared by reset and by flush.
- Undefined:
  - stall_cnt is tied to 32'h0.
  - No counter flops are synthesised.
  - Handshake behaviour is identical.

Test Plan:
- Reset and idle: hold reset=0 with in_valid=1 and in_data=8'hAA -> out_valid=0, in_ready=1, out_data=0. Release reset, then in_valid=1 with 8'h11 -> next cycle out_valid=1, out_data=8'h11.
- Streaming: out_ready=1, push 8'h01..8'h10 on consecutive cycles -> outputs 8'h01..8'h10 on consecutive cycles, one cycle later. in_ready stays 1 throughout.
- Back-pressure fill: out_ready=0, push 8'hA1 then 8'hA2 -> in_ready=0 after the second fire. 8'hA3 is held upstream and not accepted. out_data stays 8'hA1.
- Drain order: from that FULL state, set out_ready=1 -> outputs 8'hA1, 8'hA2, 8'hA3 on consecutive cycles. in_ready returns to 1 the cycle after the first out_fire.
- Flush and async reset: in FULL with in_valid=1 and 8'hB0, pulse flush -> next cycle out_valid=0, in_ready=1, and 8'hB0 is never emitted. Assert reset mid-cycle while ONE -> out_valid drops to 0 immediately, without waiting for a clock edge.
- Counter (macro defined): hold out_valid with out_ready=0 for 5 cycles -> stall_cnt=5. Flush -> stall_cnt=0. Macro undefined -> stall_cnt=0 throughout.
